alu_issue_unit: RTL and testbench

Execute-stage issuer and result collector for the RV32 core's combinational ALU. It accepts one decoded instruction per valid/ready handshake and maps opcode/funct3/funct7 onto the ALU's 5-bit operation code. It drives the ALU operand and select inputs from registers, then captures the ALU result and zero flag one cycle later. It returns the result, writeback and branch-decision information to the writeback/fetch side over a second valid/ready handshake.

---
 rtl/alu_issue_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Execute-stage issuer: decodes one RV32 ALU/branch instruction, drives the
// external combinational ALU from registers, captures its result one cycle
// later and presents it over a valid/ready handshake to writeback/fetch.
//
// state | meaning
// IDLE  | no instruction in flight, ready to accept
// EXEC  | ALU operands driven, result captured on the next edge
// DONE  | result presented, waiting for out_ready
module alu_issue_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [4:0]      alu_sel,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_zero,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic            out_branch,
   output logic            out_taken,
   output logic            out_illegal
);

   localparam logic [4:0] SEL_ADD = 5'b00000;
   localparam logic [4:0] SEL_SUB = 5'b00010;
   localparam logic [4:0] SEL_AND = 5'b11100;
   localparam logic [4:0] SEL_XOR = 5'b10000;
   localparam logic [4:0] SEL_SLL = 5'b00100;
   localparam logic [4:0] SEL_SRL = 5'b10100;
   localparam logic [4:0] SEL_SRA = 5'b10110;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t          state;
   logic            accept;
   logic            is_r, is_i;
   logic [XLEN-1:0] operand;
   logic            dec_legal, dec_we, dec_branch, dec_bne;
   logic [4:0]      dec_sel;
   logic [XLEN-1:0] dec_b;
   logic            pend_we, pend_branch, pend_bne, pend_illegal;
   logic [4:0]      pend_rd;

   assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
   assign accept   = in_valid && in_ready;

   // Decode opcode/funct3/funct7_5 into ALU select, operand B and writeback flags
   always_comb begin
      dec_legal  = 1'b0;
      dec_sel    = SEL_ADD;
      dec_b      = '0;
      dec_we     = 1'b0;
      dec_branch = 1'b0;
      dec_bne    = 1'b0;
      is_r       = (in_opcode == OP_R);
      is_i       = (in_opcode == OP_I);
      operand    = is_r ? in_rs2 : in_imm;
      if (is_r || is_i) begin
         dec_legal = 1'b1;
         dec_b     = operand;
         case (in_funct3)
            3'b000: dec_sel = (is_r && in_funct7_5) ? SEL_SUB : SEL_ADD;
            3'b001: begin
               dec_sel = SEL_SLL;
               dec_b   = {{(XLEN-5){1'b0}}, operand[4:0]};
            end
            3'b100: dec_sel = SEL_XOR;
            3'b101: begin
               dec_sel = in_funct7_5 ? SEL_SRA : SEL_SRL;
               dec_b   = {{(XLEN-5){1'b0}}, operand[4:0]};
            end
            3'b111: dec_sel = SEL_AND;
            default: dec_legal = 1'b0;
         endcase
         dec_we = dec_legal && (in_rd != 5'd0);
      end else if (in_opcode == OP_BR && (in_funct3 == 3'b000 || in_funct3 == 3'b001)) begin
         dec_legal  = 1'b1;
         dec_sel    = SEL_SUB;
         dec_b      = in_rs2;
         dec_branch = 1'b1;
         dec_bne    = in_funct3[0];
      end
      // Illegal encodings run a harmless 0+0 through the ALU
      if (!dec_legal) begin
         dec_sel = SEL_ADD;
         dec_b   = '0;
      end
   end

   // Issue/capture FSM with registered ALU drive and result payload
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= '0;
         pend_we      <= 1'b0;
         pend_branch  <= 1'b0;
         pend_bne     <= 1'b0;
         pend_illegal <= 1'b0;
         pend_rd      <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_we       <= 1'b0;
         out_branch   <= 1'b0;
         out_taken    <= 1'b0;
         out_illegal  <= 1'b0;
      end else begin
         if (accept) begin
            alu_a        <= dec_legal ? in_rs1 : '0;
            alu_b        <= dec_b;
            alu_sel      <= dec_sel;
            pend_we      <= dec_we;
            pend_branch  <= dec_branch;
            pend_bne     <= dec_bne;
            pend_illegal <= !dec_legal;
            pend_rd      <= in_rd;
         end
         case (state)
            IDLE: if (accept) state <= EXEC;
            EXEC: begin
               out_result  <= pend_illegal ? '0 : alu_out;
               out_rd      <= pend_rd;
               out_we      <= pend_we;
               out_branch  <= pend_branch;
               out_taken   <= pend_branch && (pend_bne ? !alu_zero : alu_zero);
               out_illegal <= pend_illegal;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= accept ? EXEC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU on the DUT's ALU port, directed
// scenarios from the feature list, then randomized instructions compared
// against an instruction-level reference model.
module tb_alu_issue_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [31:0] in_rs1, in_rs2, in_imm;
   logic [4:0]  in_rd;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_sel;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_we, out_branch, out_taken, out_illegal;

   int checks = 0;
   int errors = 0;

   alu_issue_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_we(out_we), .out_branch(out_branch),
      .out_taken(out_taken), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // External combinational ALU the unit is meant to drive
   always_comb begin
      case (alu_sel)
         5'b00000: alu_out = alu_a + alu_b;
         5'b00010: alu_out = alu_a - alu_b;
         5'b11100: alu_out = alu_a & alu_b;
         5'b10000: alu_out = alu_a ^ alu_b;
         5'b00100: alu_out = alu_a << alu_b[4:0];
         5'b10100: alu_out = alu_a >> alu_b[4:0];
         5'b10110: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default:  alu_out = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   typedef struct {
      logic [31:0] a, b, res;
      logic [4:0]  sel;
      logic        we, br, tk, ill;
   } exp_t;

   // Instruction-level reference: what each RV32 instruction means
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [4:0] rd);
      exp_t e;
      logic [31:0] opnd;
      logic [4:0]  sh;
      e = '{a: 0, b: 0, res: 0, sel: 0, we: 0, br: 0, tk: 0, ill: 1};
      if (op == 7'b0110011 || op == 7'b0010011) begin
         opnd  = (op == 7'b0110011) ? rs2 : imm;
         sh    = opnd[4:0];
         e.ill = 1'b0;
         case (f3)
            3'd0: if (op == 7'b0110011 && f7) begin e.sel = 5'b00010; e.b = opnd; e.res = rs1 - opnd; end
                  else begin e.sel = 5'b00000; e.b = opnd; e.res = rs1 + opnd; end
            3'd1: begin e.sel = 5'b00100; e.b = {27'd0, sh}; e.res = rs1 << sh; end
            3'd4: begin e.sel = 5'b10000; e.b = opnd; e.res = rs1 ^ opnd; end
            3'd5: if (f7) begin e.sel = 5'b10110; e.b = {27'd0, sh}; e.res = $unsigned($signed(rs1) >>> sh); end
                  else begin e.sel = 5'b10100; e.b = {27'd0, sh}; e.res = rs1 >> sh; end
            3'd7: begin e.sel = 5'b11100; e.b = opnd; e.res = rs1 & opnd; end
            default: e.ill = 1'b1;
         endcase
         if (!e.ill) begin
            e.a  = rs1;
            e.we = (rd != 0);
         end
      end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
         e.ill = 1'b0;
         e.a   = rs1;
         e.b   = rs2;
         e.sel = 5'b00010;
         e.res = rs1 - rs2;
         e.br  = 1'b1;
         e.tk  = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
      end
      if (e.ill) e = '{a: 0, b: 0, res: 0, sel: 0, we: 0, br: 0, tk: 0, ill: 1};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd);
      in_opcode = op; in_funct3 = f3; in_funct7_5 = f7;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
   endtask

   task automatic scramble();
      drive(7'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
   endtask

   task automatic chk_payload(input string tag, input exp_t e, input logic [4:0] rd);
      chk({tag, "_valid"},   {31'd0, out_valid},   32'd1);
      chk({tag, "_result"},  out_result,           e.res);
      chk({tag, "_rd"},      {27'd0, out_rd},      {27'd0, rd});
      chk({tag, "_we"},      {31'd0, out_we},      {31'd0, e.we});
      chk({tag, "_branch"},  {31'd0, out_branch},  {31'd0, e.br});
      chk({tag, "_taken"},   {31'd0, out_taken},   {31'd0, e.tk});
      chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
   endtask

   // One full instruction from IDLE: accept, issue, capture, hold, release
   task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [4:0] rd, input int stall);
      exp_t e;
      e = model(op, f3, f7, rs1, rs2, imm, rd);
      @(negedge clk);
      drive(op, f3, f7, rs1, rs2, imm, rd);
      in_valid = 1'b1;
      #1 chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
      chk({tag, "_alu_a"},   alu_a, e.a);
      chk({tag, "_alu_b"},   alu_b, e.b);
      chk({tag, "_alu_sel"}, {27'd0, alu_sel}, {27'd0, e.sel});
      chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk_payload(tag, e, rd);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk_payload({tag, "_hold"}, e, rd);
         chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_released"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      exp_t e1, e2;
      logic [6:0] rop;
      logic [31:0] r1, r2;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      scramble();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_a",     alu_a, 32'd0);
      chk("rst_alu_b",     alu_b, 32'd0);
      chk("rst_alu_sel",   {27'd0, alu_sel}, 32'd0);
      chk("rst_result",    out_result, 32'd0);
      chk("rst_flags",     {26'd0, out_rd, out_we, out_branch, out_taken, out_illegal}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;

      run_instr("add",   7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 0);
      chk("add_const", out_result, 32'd12);
      run_instr("slli",  7'b0010011, 3'd1, 1'b0, 32'd1, 32'd0, 32'h23, 5'd4, 0);
      run_instr("srli",  7'b0010011, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'd31, 5'd5, 1);
      run_instr("sra",   7'b0110011, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 5'd6, 0);
      run_instr("sub",   7'b0110011, 3'd0, 1'b1, 32'd3, 32'd10, 32'd0, 5'd7, 0);
      run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 32'd3, 32'd10, 32'd9, 5'd8, 0);
      run_instr("beq_eq",  7'b1100011, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'd0, 5'd0, 0);
      run_instr("bne_eq",  7'b1100011, 3'd1, 1'b0, 32'h1234, 32'h1234, 32'd0, 5'd0, 0);
      run_instr("beq_ne",  7'b1100011, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0, 0);
      run_instr("or_ill",  7'b0110011, 3'd6, 1'b0, 32'hFFFF, 32'h1, 32'd0, 5'd9, 0);
      run_instr("blt_ill", 7'b1100011, 3'd4, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9, 0);
      run_instr("add_rd0", 7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0, 0);

      // Backpressure with a new instruction waiting, then same-edge accept
      e1 = model(7'b0110011, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 5'd10);
      e2 = model(7'b0010011, 3'd7, 1'b0, 32'hABCD, 32'd0, 32'h00FF, 5'd11);
      @(negedge clk);
      drive(7'b0110011, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 5'd10);
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(7'b0010011, 3'd7, 1'b0, 32'hABCD, 32'd0, 32'h00FF, 5'd11);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk_payload("bp_hold", e1, 5'd10);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp_ready_through", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      scramble();
      chk("bp_drop", {31'd0, out_valid}, 32'd0);
      chk("bp_sel2", {27'd0, alu_sel}, {27'd0, e2.sel});
      @(posedge clk); #1;
      chk_payload("bp_second", e2, 5'd11);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk("bp_drain", {31'd0, out_valid}, 32'd0);

      // Reset while in EXEC discards the instruction
      @(negedge clk);
      drive(7'b0110011, 3'd0, 1'b0, 32'd100, 32'd200, 32'd0, 5'd12);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", out_result, 32'd0);
      chk("mid_rst_flags",  {26'd0, out_rd, out_we, out_branch, out_taken, out_illegal}, 32'd0);
      chk("mid_rst_ready",  {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("post_rst_no_result", {31'd0, out_valid}, 32'd0);

      // Randomized instructions against the reference model
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: rop = 7'b0110011;
            1: rop = 7'b0010011;
            2: rop = 7'b1100011;
            default: rop = 7'($urandom);
         endcase
         r1 = $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
         run_instr("rand", rop, 3'($urandom), 1'($urandom), r1, r2, $urandom,
                   5'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
